// File: rtl/gc_poll_if.sv
// Signal bundle between the GameCube poller and its host/line side.
// The poller uses the master view; the host, pad and bench use the slave view.
`timescale 1ns/1ps
interface gc_poll_if;
    logic        enable;
    logic        rumble;
    logic        gc_in;
    logic        gc_oe;
    logic [63:0] controller_data;
    logic        data_valid;
    logic        busy;
    logic        timeout_err;

    modport master (
        input  enable, rumble, gc_in,
        output gc_oe, controller_data, data_valid, busy, timeout_err
    );

    modport slave (
        output enable, rumble, gc_in,
        input  gc_oe, controller_data, data_valid, busy, timeout_err
    );
endinterface

// File: rtl/gc_poll.sv
// Single-wire GameCube controller poller: sends the 24-bit poll command on an
// open-drain line, captures the 64-bit reply and flags missing responses.
`timescale 1ns/1ps
module gc_poll #(
    parameter int unsigned CLK_PER_US     = 10,
    parameter int unsigned POLL_PERIOD_US = 10000,
    parameter int unsigned RX_TIMEOUT_US  = 200
) (
    input  logic      SYSCLK,
    input  logic      NSYSRESET,
    gc_poll_if.master gc
);
    localparam int unsigned BIT_CYC  = 4 * CLK_PER_US;
    localparam int unsigned TMO_CYC  = RX_TIMEOUT_US * CLK_PER_US;
    localparam int unsigned POLL_CYC = POLL_PERIOD_US * CLK_PER_US;
    localparam int unsigned CW = $clog2(BIT_CYC + 1);
    localparam int unsigned TW = $clog2(TMO_CYC + 1);
    localparam int unsigned PW = $clog2(POLL_CYC + 1);

    localparam logic [CW-1:0] ONE_US    = CW'(CLK_PER_US);
    localparam logic [CW-1:0] THREE_US  = CW'(3 * CLK_PER_US);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(2 * CLK_PER_US - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLK_PER_US - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, TX, TX_STOP, RX_WAIT, RX_SAMPLE, RX_STOP, DONE, ERR
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [6:0]    bit_cnt, bit_d;
    logic [TW-1:0] tmo, tmo_d;
    logic [23:0]   cmd, cmd_d;
    logic [63:0]   sr, sr_d;
    logic [PW-1:0] timer;
    logic [2:0]    sync;
    logic          oe_d;
    logic          gc_oe_q, dv_q, busy_q, tmo_err_q;
    logic [63:0]   data_q;

    logic rx, fall, poll_tick, start;
    assign rx        = sync[1];
    assign fall      = sync[2] & ~sync[1];
    assign poll_tick = gc.enable && (timer == POLL_LAST);
    assign start     = (state == IDLE) && poll_tick;

    // Counts up from zero so the reset value is zero and the first frame still
    // lands one full poll period after reset release.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET)                  timer <= '0;
        else if (!gc.enable || poll_tick) timer <= '0;
        else                              timer <= timer + 1'b1;
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) sync <= '1;
        else            sync <= {sync[1:0], gc.gc_in};
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        bit_d   = bit_cnt;
        tmo_d   = tmo;
        cmd_d   = cmd;
        sr_d    = sr;
        oe_d    = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (poll_tick) begin
                    state_d = TX;
                    cmd_d   = {16'h4003, 7'b0, gc.rumble};
                    bit_d   = '0;
                end
            end
            TX: begin
                oe_d = cmd[23] ? (cnt < ONE_US) : (cnt < THREE_US);
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    cmd_d = {cmd[22:0], 1'b0};
                    bit_d = bit_cnt + 1'b1;
                    if (bit_cnt == 7'd23) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                oe_d = 1'b1;
                if (cnt == STOP_LAST) begin
                    state_d = RX_WAIT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tmo_d   = '0;
                end
            end
            RX_WAIT: begin
                cnt_d = '0;
                tmo_d = tmo + 1'b1;
                if (fall)                 state_d = RX_SAMPLE;
                else if (tmo == TMO_LAST) state_d = ERR;
            end
            RX_SAMPLE: begin
                if (cnt == SAMPLE_AT) begin
                    sr_d    = {sr[62:0], rx};
                    bit_d   = bit_cnt + 1'b1;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = (bit_cnt == 7'd63) ? RX_STOP : RX_WAIT;
                end
            end
            RX_STOP: begin
                cnt_d = '0;
                tmo_d = tmo + 1'b1;
                if (fall || tmo == TMO_LAST) state_d = DONE;
            end
            DONE, ERR: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tmo       <= '0;
            cmd       <= '0;
            sr        <= '0;
            gc_oe_q   <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_d;
            tmo     <= tmo_d;
            cmd     <= cmd_d;
            sr      <= sr_d;
            gc_oe_q <= oe_d;
            dv_q    <= (state == DONE);
            if (state == DONE) data_q <= sr;
            if (start) begin
                busy_q    <= 1'b1;
                tmo_err_q <= 1'b0;
            end else if (state == DONE || state == ERR) begin
                busy_q <= 1'b0;
            end
            if (state == ERR) tmo_err_q <= 1'b1;
        end
    end

    assign gc.gc_oe           = gc_oe_q;
    assign gc.controller_data = data_q;
    assign gc.data_valid      = dv_q;
    assign gc.busy            = busy_q;
    assign gc.timeout_err     = tmo_err_q;
endmodule

// File: tb/tb_gc_poll.sv
// Frame-level bench for gc_poll: decodes the transmitted command from gc_oe
// pulse widths and answers with an open-drain controller model.
`timescale 1ns/1ps
module tb_gc_poll;
    localparam int unsigned CPU      = 10;
    localparam int unsigned PP       = 500;
    localparam int unsigned RT       = 200;
    localparam int unsigned POLL_CYC = PP * CPU;

    logic clk = 1'b0;
    logic rst_n;
    logic model_low;
    logic line_tied;
    int unsigned applied = 0;
    int unsigned miscompares = 0;
    int unsigned dv_total = 0;

    gc_poll_if bus();
    assign bus.gc_in = line_tied | ~(bus.gc_oe | model_low);

    gc_poll #(.CLK_PER_US(CPU), .POLL_PERIOD_US(PP), .RX_TIMEOUT_US(RT)) dut (
        .SYSCLK   (clk),
        .NSYSRESET(rst_n),
        .gc       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.data_valid === 1'b1) dv_total <= dv_total + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rumble;
        logic        toggle;
        logic        drop_en;
        int unsigned nbits;
        logic [63:0] reply;
        logic [23:0] exp_cmd;
        int unsigned exp_dv;
        logic [63:0] exp_data;
        logic        exp_tmo;
    } vec_t;

    vec_t vecs[5];
    vec_t drop_vec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s: got no event within bound, want event", name);
    endtask

    task automatic wait_busy(input logic lvl, input int unsigned bound, input string name,
                             output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.busy === lvl) begin ok = 1'b1; break; end
        end
        if (!ok) expired(name);
    endtask

    task automatic wait_oe(input logic lvl, input int unsigned bound, input string name,
                           output int unsigned n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (bus.gc_oe === lvl) begin ok = 1'b1; break; end
        end
        if (!ok) expired(name);
    endtask

    task automatic send_bit(input logic b);
        int unsigned low_w;
        low_w = b ? 10 : 30;
        model_low = 1'b1;
        repeat (low_w) @(negedge clk);
        model_low = 1'b0;
        repeat (40 - low_w) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gc_oe"}, bus.gc_oe, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_data_valid"}, bus.data_valid, 0);
        chk({tag, "_timeout_err"}, bus.timeout_err, 0);
        chk({tag, "_controller_data"}, bus.controller_data, 64'h0);
    endtask

    task automatic run_frame(input vec_t v);
        int unsigned n, low_w, high_w, stop_w, bad, dv0;
        logic [23:0] cmd;
        bit ok;
        line_tied = (v.nbits == 0);
        bus.rumble = v.rumble;
        dv0 = dv_total;
        wait_busy(1'b1, POLL_CYC + 1000, "frame_start", ok);
        if (!ok) return;
        chk("tmo_clear_at_start", bus.timeout_err, 0);
        wait_oe(1'b1, 10, "tx_first_low", n, ok);
        cmd = '0;
        bad = 0;
        low_w = 0;
        high_w = 0;
        for (int i = 0; i < 24; i++) begin
            wait_oe(1'b0, 100, "tx_low", low_w, ok);
            wait_oe(1'b1, 100, "tx_high", high_w, ok);
            if (!(low_w == 10 || low_w == 30) || (low_w + high_w) != 40) bad++;
            cmd = {cmd[22:0], low_w == 10};
            if (v.toggle && i == 5) bus.rumble = ~bus.rumble;
        end
        chk("tx_cmd", cmd, v.exp_cmd);
        chk("tx_bad_bits", bad, 0);
        chk("tx_last_low", low_w, v.exp_cmd[0] ? 10 : 30);
        chk("tx_last_high", high_w, v.exp_cmd[0] ? 30 : 10);
        wait_oe(1'b0, 100, "tx_stop", stop_w, ok);
        chk("tx_stop_width", stop_w, 10);
        if (v.nbits > 0) begin
            repeat (20) @(negedge clk);
            for (int unsigned i = 0; i < v.nbits; i++) begin
                send_bit(v.reply[63 - i]);
                if (v.drop_en && i == 9) bus.enable = 1'b0;
            end
            if (v.nbits == 64) send_bit(1'b1);
        end
        wait_busy(1'b0, 4000, "frame_end", ok);
        repeat (3) @(negedge clk);
        chk("dv_pulses", dv_total - dv0, v.exp_dv);
        chk("controller_data", bus.controller_data, v.exp_data);
        chk("timeout_err", bus.timeout_err, v.exp_tmo);
        chk("busy_after", bus.busy, 0);
    endtask

    initial begin
        int unsigned n, active;
        bit ok;
        //         rumble tog  drop nbits reply                    cmd        dv data                     tmo
        vecs[0] = '{1'b0, 1'b0, 1'b0, 0,  64'h0,                   24'h400300, 0, 64'h0,                   1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 64, 64'h0080_8080_8080_0000, 24'h400300, 1, 64'h0080_8080_8080_0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 64, 64'h1234_5678_9ABC_DEF0, 24'h400301, 1, 64'h1234_5678_9ABC_DEF0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 40, 64'hFFFF_0000_FF00_0000, 24'h400300, 0, 64'h1234_5678_9ABC_DEF0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 64, 64'hA5A5_5A5A_C3C3_3C3C, 24'h400300, 1, 64'hA5A5_5A5A_C3C3_3C3C, 1'b0};
        drop_vec = '{1'b0, 1'b0, 1'b1, 64, 64'h0F0F_1234_8000_7FFE, 24'h400300, 1, 64'h0F0F_1234_8000_7FFE, 1'b0};

        rst_n = 1'b0;
        model_low = 1'b0;
        line_tied = 1'b0;
        bus.enable = 1'b1;
        bus.rumble = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset asserted mid-TX while the line is being pulled low.
        line_tied = 1'b0;
        wait_busy(1'b1, POLL_CYC + 1000, "rst_tx_frame", ok);
        wait_oe(1'b1, 10, "rst_tx_low", n, ok);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_tx");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < POLL_CYC + 100) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) break;
        end
        chk("rst_tx_first_frame_cycles", n, POLL_CYC);

        // Reset asserted mid-RX while waiting for a reply.
        repeat (1500) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_rx");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < POLL_CYC + 100) begin
            @(negedge clk);
            n++;
            if (bus.busy === 1'b1) break;
        end
        chk("rst_rx_first_frame_cycles", n, POLL_CYC);
        wait_busy(1'b0, 4000, "rst_rx_frame_end", ok);

        // Enable dropped during the reply: frame completes, then the line stays quiet.
        run_frame(drop_vec);
        active = 0;
        for (int unsigned i = 0; i < 2 * POLL_CYC; i++) begin
            @(negedge clk);
            if (bus.gc_oe !== 1'b0 || bus.busy !== 1'b0) active++;
        end
        chk("idle_after_disable", active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/gc_poll.md
Name: gc_poll

Overview:
- Single-wire GameCube controller poller in the gc fabric, directly upstream of the gc top-level `controller_data` output.
- Periodically sends the 24-bit poll command (0x4003_0R, where R is the rumble bit) over the open-drain data line.
- Receives the 64-bit controller response and presents it as a stable register with a one-cycle valid strobe.
- Flags missing or malformed responses.

Parameters:
- CLK_PER_US, 10, SYSCLK cycles per microsecond (10 = 10 MHz SYSCLK); all protocol timing derives from it.
- POLL_PERIOD_US, 10000, interval between poll starts while enabled, in µs.
- RX_TIMEOUT_US, 200, maximum wait for a falling edge during the response, in µs.

Ports:
- SYSCLK  in  1  system clock.
- NSYSRESET  in  1  asynchronous active-low reset.
- enable  in  1  auto-poll enable.
- rumble  in  1  rumble request, sampled at frame start into command bit 0.
- gc_in  in  1  raw data line level, asynchronous.
- gc_oe  out  1  1 = pull line low; 0 = release (external pull-up).
- controller_data  out  64  last good response, MSB = first bit received.
- data_valid  out  1  one-cycle pulse when controller_data updates.
- busy  out  1  high from frame start until DONE or ERR exits.
- timeout_err  out  1  sticky; set on response timeout; cleared at next frame start.

Behaviour:
- Reset values (asynchronous on NSYSRESET low, any state): gc_oe=0, controller_data=0, data_valid=0, busy=0, timeout_err=0, state=IDLE, all counters=0, synchronizer flops=1.
- Input synchronizer: gc_in passes through a 2-flop synchronizer (flops reset to 1); falling-edge detect compares against one further delayed copy; all RX decisions use the synchronized value.
- Bit time: 1 µs = CLK_PER_US cycles; one bit = 4 µs.
- Encoding: 0 = 3 µs low, 1 µs high. 1 = 1 µs low, 3 µs high. Stop = 1 µs low, then release.
- Poll timer: free-running while enable=1; reloads to POLL_PERIOD_US·CLK_PER_US−1; held at reload value while enable=0.
- IDLE:
  - On timer expiry with enable=1: latch command {0x4003, 7'b0, rumble}, clear timeout_err, assert busy, go TX.
- TX:
  - 24 bits, MSB first, each exactly 4·CLK_PER_US cycles.
  - gc_oe=1 for the low phase, 0 for the high phase.
- TX_STOP:
  - gc_oe=1 for CLK_PER_US cycles, then 0.
  - Go RX_WAIT with bit counter=0 and timeout counter cleared.
- RX_WAIT:
  - gc_oe=0.
  - On synchronized falling edge: go RX_SAMPLE.
  - If timeout counter reaches RX_TIMEOUT_US·CLK_PER_US: set timeout_err, go ERR.
- RX_SAMPLE:
  - After 2·CLK_PER_US cycles from the edge, shift the synchronized level into the shift register (LSB in); bit counter++.
  - If bit counter <64: RX_WAIT, timeout counter cleared.
  - If bit counter =64: wait for the stop-bit falling edge, or for the timeout (timeout is not an error here), then go DONE.
- DONE (1 cycle): controller_data ← shift register, data_valid=1, busy=0 on the next cycle, go IDLE.
- ERR (1 cycle): controller_data unchanged, no data_valid, busy=0, go IDLE.
- Edges during TX are ignored; the line echo is not checked.
- enable going to 0 mid-frame: the frame completes; no new frame starts.
- Timer expiry while busy: ignored; the timer reloads.
- gc_oe is never 1 outside TX/TX_STOP low phases.
- Total TX duration: 25·4·CLK_PER_US − 3·CLK_PER_US cycles; gc_oe releases at this point.

Test Plan:
1. Reset then enable=1, rumble=0, CLK_PER_US=10, POLL_PERIOD_US=500, gc_in tied to 1:
   - gc_oe low-pulse widths decode to 0x400300, then a 10-cycle stop pulse.
   - After 2000 idle cycles: timeout_err=1, busy=0, no data_valid, controller_data=0.
2. Bus model answers 0x0080_8080_8080_0000 with correct bit timing after the stop bit:
   - data_valid pulses exactly once.
   - controller_data=0x0080808080800000.
   - timeout_err=0.
3. rumble=1 at frame start:
   - last command bit is a 1 (10 cycles low, 30 high).
   - rumble toggled mid-frame does not change the current frame.
4. Model sends only 40 bits then holds line high:
   - timeout_err=1.
   - controller_data keeps the previous good value.
   - the next frame start clears timeout_err.
5. NSYSRESET asserted mid-TX and mid-RX:
   - gc_oe=0 and all outputs reset immediately (asynchronous).
   - the first new frame starts POLL_PERIOD_US after release.
6. enable deasserted during RX:
   - the frame finishes with data_valid.
   - no gc_oe activity afterwards for at least 2·POLL_PERIOD_US.
